// File: rtl/dcache_mshr_pkg.sv
// Shared dcache types for the miss-status holding registers: bus command encoding,
// entry state and the entry record. Block width comes from `DCACHE_BLOCK_SIZE.
`ifndef DCACHE_BLOCK_SIZE
`define DCACHE_BLOCK_SIZE 64
`endif

package dcache_mshr_pkg;

    localparam int BLOCK_BITS = `DCACHE_BLOCK_SIZE;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_cmd_e;

    typedef enum logic [1:0] {
        MSHR_EMPTY      = 2'd0,
        MSHR_WAIT_ISSUE = 2'd1,
        MSHR_WAIT_DATA  = 2'd2
    } mshr_state_e;

    typedef struct packed {
        mshr_state_e           state;
        logic [63:0]           addr;
        logic [BLOCK_BITS-1:0] data;
        logic                  is_wb;
        logic                  is_store;
        logic [3:0]            tag;
    } mshr_entry_t;

    function automatic logic [63:0] block_addr(input logic [63:0] a);
        return a & ~64'h7;
    endfunction

endpackage

// File: rtl/dcache_mshr_fifo.sv
// In-order issue queue of MSHR entry indices; head is valid whenever empty is low.
module dcache_mshr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] slot_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = slot_q[rd_ptr_q];

    always_ff @(posedge clock) begin
        if (do_push) begin
            slot_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

endmodule

// File: rtl/dcache_mshr.sv
// Data-cache MSHR: tracks outstanding fills/writebacks, issues them in allocation order,
// matches memory tags back to entries. Define DCACHE_MSHR_MERGE_EN to merge duplicate fills.
module dcache_mshr
    import dcache_mshr_pkg::*;
#(
    parameter int MSHR_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  miss_valid,
    input  logic                  miss_is_wb,
    input  logic                  miss_is_store,
    input  logic [63:0]           miss_addr,
    input  logic [BLOCK_BITS-1:0] miss_data,
    output logic                  miss_ready,
    output logic [1:0]            proc2mem_command,
    output logic [63:0]           proc2mem_addr,
    output logic [BLOCK_BITS-1:0] proc2mem_data,
    input  logic [3:0]            mem2proc_response,
    input  logic [BLOCK_BITS-1:0] mem2proc_data,
    input  logic [3:0]            mem2proc_tag,
    output logic                  fill_valid,
    output logic [63:0]           fill_addr,
    output logic [BLOCK_BITS-1:0] fill_data,
    output logic                  fill_is_store,
    output logic                  busy
);
    localparam int IDX_W = $clog2(MSHR_DEPTH);

    mshr_entry_t           entry_q [MSHR_DEPTH];
    mshr_entry_t           entry_d [MSHR_DEPTH];
    mshr_entry_t           head;

    logic [MSHR_DEPTH-1:0] empty_vec;
    logic [MSHR_DEPTH-1:0] tag_hit_vec;
    logic [MSHR_DEPTH-1:0] merge_vec;
    logic [IDX_W-1:0]      alloc_idx;
    logic [IDX_W-1:0]      cmp_idx;
    logic [IDX_W-1:0]      merge_idx;
    logic [IDX_W-1:0]      head_idx;
    logic                  any_empty;
    logic                  cmp_valid;
    logic                  merge_hit;
    logic                  do_alloc;
    logic                  do_merge;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;

    logic                  fill_valid_d;
    logic [63:0]           fill_addr_d;
    logic [BLOCK_BITS-1:0] fill_data_d;
    logic                  fill_is_store_d;

    genvar gi;
    generate
        for (gi = 0; gi < MSHR_DEPTH; gi++) begin : g_entry
            assign empty_vec[gi]   = (entry_q[gi].state == MSHR_EMPTY);
            assign tag_hit_vec[gi] = (mem2proc_tag != 4'd0)
                                  && (entry_q[gi].state == MSHR_WAIT_DATA)
                                  && (entry_q[gi].tag == mem2proc_tag);
`ifdef DCACHE_MSHR_MERGE_EN
            assign merge_vec[gi]   = miss_valid && !miss_is_wb && !empty_vec[gi]
                                  && !entry_q[gi].is_wb
                                  && (entry_q[gi].addr == block_addr(miss_addr));
`else
            assign merge_vec[gi]   = 1'b0;
`endif
        end
    endgenerate

    // Lowest index wins for allocation, tag match and merge target.
    always_comb begin
        alloc_idx = '0;
        cmp_idx   = '0;
        merge_idx = '0;
        for (int i = MSHR_DEPTH - 1; i >= 0; i--) begin
            if (empty_vec[i])   alloc_idx = IDX_W'(i);
            if (tag_hit_vec[i]) cmp_idx   = IDX_W'(i);
            if (merge_vec[i])   merge_idx = IDX_W'(i);
        end
    end

    assign any_empty  = |empty_vec;
    assign cmp_valid  = |tag_hit_vec;
    assign merge_hit  = |merge_vec;
    assign busy       = ~&empty_vec;
    assign miss_ready = !reset && (any_empty || merge_hit);
    assign do_merge   = merge_hit;
    assign do_alloc   = miss_valid && miss_ready && !merge_hit && !fifo_full;
    assign fifo_pop   = !fifo_empty && (mem2proc_response != 4'd0);
    assign head       = entry_q[head_idx];

    dcache_mshr_fifo #(
        .DEPTH (MSHR_DEPTH),
        .WIDTH (IDX_W)
    ) u_issue_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (do_alloc),
        .push_data (alloc_idx),
        .pop       (fifo_pop),
        .head      (head_idx),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        if (!fifo_empty) begin
            proc2mem_command = head.is_wb ? BUS_STORE : BUS_LOAD;
            proc2mem_addr    = head.addr;
            if (head.is_wb) begin
                proc2mem_data = head.data;
            end
        end
    end

    // Merge, issue, completion and allocation each touch a different entry (or different fields).
    always_comb begin
        for (int i = 0; i < MSHR_DEPTH; i++) begin
            entry_d[i] = entry_q[i];
        end
        if (do_merge) begin
            entry_d[merge_idx].is_store = entry_q[merge_idx].is_store | miss_is_store;
        end
        if (fifo_pop) begin
            if (head.is_wb) begin
                entry_d[head_idx].state = MSHR_EMPTY;
            end else begin
                entry_d[head_idx].state = MSHR_WAIT_DATA;
                entry_d[head_idx].tag   = mem2proc_response;
            end
        end
        if (cmp_valid) begin
            entry_d[cmp_idx].state = MSHR_EMPTY;
            entry_d[cmp_idx].data  = mem2proc_data;
        end
        if (do_alloc) begin
            entry_d[alloc_idx] = '{state:    MSHR_WAIT_ISSUE,
                                   addr:     block_addr(miss_addr),
                                   data:     miss_data,
                                   is_wb:    miss_is_wb,
                                   is_store: miss_is_store,
                                   tag:      4'd0};
        end
    end

    always_comb begin
        fill_valid_d    = cmp_valid;
        fill_addr_d     = '0;
        fill_data_d     = '0;
        fill_is_store_d = 1'b0;
        if (cmp_valid) begin
            fill_addr_d     = entry_q[cmp_idx].addr;
            fill_data_d     = mem2proc_data;
            // A store merging into the entry that completes this cycle still marks the fill.
            fill_is_store_d = entry_q[cmp_idx].is_store
                            | (do_merge && (merge_idx == cmp_idx) && miss_is_store);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MSHR_DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            fill_valid    <= 1'b0;
            fill_addr     <= '0;
            fill_data     <= '0;
            fill_is_store <= 1'b0;
        end else begin
            for (int i = 0; i < MSHR_DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
            fill_valid    <= fill_valid_d;
            fill_addr     <= fill_addr_d;
            fill_data     <= fill_data_d;
            fill_is_store <= fill_is_store_d;
        end
    end

endmodule

// File: tb/tb_dcache_mshr.sv
// Bench for dcache_mshr: queue-based reference model checked every cycle, directed scenarios
// with literal expectations, then randomized traffic. Honours DCACHE_MSHR_MERGE_EN.
module tb_dcache_mshr;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss_valid, miss_is_wb, miss_is_store;
    logic [63:0] miss_addr, miss_data;
    logic        miss_ready;
    logic [1:0]  proc2mem_command;
    logic [63:0] proc2mem_addr, proc2mem_data;
    logic [3:0]  mem_resp, mem_tag;
    logic [63:0] mem_data;
    logic        fill_valid, fill_is_store, busy;
    logic [63:0] fill_addr, fill_data;

    int n_chk  = 0;
    int n_pass = 0;

    dcache_mshr #(.MSHR_DEPTH(DEPTH)) dut (
        .clock             (clk),
        .reset             (rst),
        .miss_valid        (miss_valid),
        .miss_is_wb        (miss_is_wb),
        .miss_is_store     (miss_is_store),
        .miss_addr         (miss_addr),
        .miss_data         (miss_data),
        .miss_ready        (miss_ready),
        .proc2mem_command  (proc2mem_command),
        .proc2mem_addr     (proc2mem_addr),
        .proc2mem_data     (proc2mem_data),
        .mem2proc_response (mem_resp),
        .mem2proc_data     (mem_data),
        .mem2proc_tag      (mem_tag),
        .fill_valid        (fill_valid),
        .fill_addr         (fill_addr),
        .fill_data         (fill_data),
        .fill_is_store     (fill_is_store),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        bit          wb;
        bit          st;
        logic [3:0]  tag;
    } rec_t;

    rec_t        iq[$];     // accepted, not yet taken by memory, in allocation order
    rec_t        pend[$];   // fills taken by memory, waiting for their tag
    int          occ = 0;   // live requests
    bit          efv = 0;
    bit          efs = 0;
    logic [63:0] efa = '0;
    logic [63:0] efd = '0;

    function automatic logic [63:0] blk(input logic [63:0] a);
        return {a[63:3], 3'b000};
    endfunction

    function automatic bit merge_match();
`ifdef DCACHE_MSHR_MERGE_EN
        if (!miss_valid || miss_is_wb) return 1'b0;
        foreach (iq[i]) if (!iq[i].wb && iq[i].addr == blk(miss_addr)) return 1'b1;
        foreach (pend[i]) if (pend[i].addr == blk(miss_addr)) return 1'b1;
`endif
        return 1'b0;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h required %h (t=%0t)", nm, got, exp, $time);
    endtask

    always @(posedge clk or posedge rst) begin : model
        rec_t r;
        bit   merged;
        bit   accept;
        if (rst) begin
            iq.delete();
            pend.delete();
            occ = 0;
            efv = 0; efa = '0; efd = '0; efs = 0;
        end else begin
            merged = 0;
`ifdef DCACHE_MSHR_MERGE_EN
            if (miss_valid && !miss_is_wb) begin
                foreach (iq[i]) if (!merged && !iq[i].wb && iq[i].addr == blk(miss_addr)) begin
                    r = iq[i]; r.st = r.st | miss_is_store; iq[i] = r; merged = 1;
                end
                foreach (pend[i]) if (!merged && pend[i].addr == blk(miss_addr)) begin
                    r = pend[i]; r.st = r.st | miss_is_store; pend[i] = r; merged = 1;
                end
            end
`endif
            accept = miss_valid && !merged && (occ < DEPTH);
            efv = 0; efa = '0; efd = '0; efs = 0;
            if (mem_tag != 4'd0) begin
                for (int i = 0; i < pend.size(); i++) begin
                    if (pend[i].tag == mem_tag) begin
                        efv = 1; efa = pend[i].addr; efd = mem_data; efs = pend[i].st;
                        pend.delete(i);
                        occ--;
                        break;
                    end
                end
            end
            if (mem_resp != 4'd0 && iq.size() != 0) begin
                r = iq.pop_front();
                if (r.wb) occ--;
                else begin
                    r.tag = mem_resp;
                    pend.push_back(r);
                end
            end
            if (accept) begin
                r.addr = blk(miss_addr); r.data = miss_data;
                r.wb = miss_is_wb; r.st = miss_is_store; r.tag = 4'd0;
                iq.push_back(r);
                occ++;
            end
        end
    end

    always @(negedge clk) begin : compare
        bit          er;
        logic [1:0]  ecmd;
        logic [63:0] ea;
        logic [63:0] ed;
        er   = !rst && ((occ < DEPTH) || merge_match());
        ecmd = 2'd0; ea = '0; ed = '0;
        if (iq.size() != 0) begin
            ecmd = iq[0].wb ? 2'd2 : 2'd1;
            ea   = iq[0].addr;
            ed   = iq[0].wb ? iq[0].data : 64'd0;
        end
        chk("miss_ready",    64'(miss_ready),       64'(er));
        chk("busy",          64'(busy),             64'(occ != 0));
        chk("proc2mem_cmd",  64'(proc2mem_command), 64'(ecmd));
        chk("proc2mem_addr", proc2mem_addr,         ea);
        chk("proc2mem_data", proc2mem_data,         ed);
        chk("fill_valid",    64'(fill_valid),       64'(efv));
        chk("fill_addr",     fill_addr,             efa);
        chk("fill_data",     fill_data,             efd);
        chk("fill_is_store", 64'(fill_is_store),    64'(efs));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #3;
    endtask

    task automatic clr();
        miss_valid = 0; miss_is_wb = 0; miss_is_store = 0;
        miss_addr = '0; miss_data = '0;
        mem_resp = '0; mem_tag = '0; mem_data = '0;
    endtask

    task automatic req(input bit wb, input bit st, input logic [63:0] a, input logic [63:0] d);
        miss_valid = 1; miss_is_wb = wb; miss_is_store = st; miss_addr = a; miss_data = d;
    endtask

    function automatic logic [3:0] free_tag();
        logic [3:0] t;
        bit         used;
        t = 4'($urandom_range(1, 15));
        for (int k = 0; k < 16; k++) begin
            used = 0;
            foreach (pend[j]) if (pend[j].tag == t) used = 1;
            if (!used) return t;
            t = (t == 4'd15) ? 4'd1 : t + 4'd1;
        end
        return 4'd1;
    endfunction

    initial begin : main
        int nf;
        int n500;
        clr();
        rst = 1;
        repeat (2) @(posedge clk);
        #1; look();
        chk("rst_ready", 64'(miss_ready),       64'd0);
        chk("rst_busy",  64'(busy),             64'd0);
        chk("rst_cmd",   64'(proc2mem_command), 64'd0);
        chk("rst_fill",  64'(fill_valid),       64'd0);
        rst = 0;
        tick();

        // single fill
        req(0, 1, 64'h100, 64'h0); look();
        chk("s1_ready", 64'(miss_ready), 64'd1);
        tick(); clr(); look();
        chk("s1_cmd",  64'(proc2mem_command), 64'd1);
        chk("s1_addr", proc2mem_addr, 64'h100);
        mem_resp = 4'd3;
        tick(); clr(); look();
        chk("s1_idle_cmd", 64'(proc2mem_command), 64'd0);
        tick();
        mem_tag = 4'd3; mem_data = 64'h0123_4567_89AB_CDEF; look();
        chk("s1_no_early_fill", 64'(fill_valid), 64'd0);
        tick(); clr(); look();
        chk("s1_fill_valid", 64'(fill_valid), 64'd1);
        chk("s1_fill_addr",  fill_addr, 64'h100);
        chk("s1_fill_data",  fill_data, 64'h0123_4567_89AB_CDEF);
        chk("s1_fill_store", 64'(fill_is_store), 64'd1);
        tick(); look();
        chk("s1_fill_drop",  64'(fill_valid), 64'd0);
        chk("s1_addr_zero",  fill_addr, 64'd0);
        chk("s1_busy",       64'(busy), 64'd0);

        // retry
        req(0, 0, 64'h100, 64'h0);
        tick(); clr(); look();
        chk("retry_c1", 64'(proc2mem_command), 64'd1);
        tick(); look();
        chk("retry_c2", 64'(proc2mem_command), 64'd1);
        tick(); mem_resp = 4'd5; look();
        chk("retry_c3", 64'(proc2mem_command), 64'd1);
        chk("retry_c3_addr", proc2mem_addr, 64'h100);
        tick(); clr(); look();
        chk("retry_none", 64'(proc2mem_command), 64'd0);
        mem_tag = 4'd5; mem_data = 64'h5555;
        tick(); clr(); look();
        chk("retry_fill", 64'(fill_valid), 64'd1);
        tick();

        // writeback before fill to the same block
        req(1, 0, 64'h200, 64'hAAAA_AAAA_AAAA_AAAA);
        tick(); req(0, 0, 64'h200, 64'h0); look();
        chk("ord_store_cmd",  64'(proc2mem_command), 64'd2);
        chk("ord_store_addr", proc2mem_addr, 64'h200);
        chk("ord_store_data", proc2mem_data, 64'hAAAA_AAAA_AAAA_AAAA);
        mem_resp = 4'd1;
        tick(); clr(); look();
        chk("ord_load_cmd",  64'(proc2mem_command), 64'd1);
        chk("ord_load_addr", proc2mem_addr, 64'h200);
        mem_resp = 4'd2;
        tick(); clr(); look();
        chk("ord_wb_nofill", 64'(fill_valid), 64'd0);
        chk("ord_busy",      64'(busy), 64'd1);
        mem_tag = 4'd2; mem_data = 64'h2222;
        tick(); clr(); look();
        chk("ord_fill_addr", fill_addr, 64'h200);
        tick();

        // out-of-order return
        req(0, 0, 64'h300, 64'h0);
        tick(); req(0, 0, 64'h400, 64'h0); mem_resp = 4'd1; look();
        chk("ooo_a_addr", proc2mem_addr, 64'h300);
        tick(); clr(); mem_resp = 4'd2; look();
        chk("ooo_b_addr", proc2mem_addr, 64'h400);
        tick(); clr(); mem_tag = 4'd2; mem_data = 64'hBBBB;
        tick(); clr(); mem_tag = 4'd1; mem_data = 64'hAAAA; look();
        chk("ooo_first_addr", fill_addr, 64'h400);
        chk("ooo_first_data", fill_data, 64'hBBBB);
        tick(); clr(); look();
        chk("ooo_second_addr", fill_addr, 64'h300);
        chk("ooo_second_data", fill_data, 64'hAAAA);
        tick(); look();
        chk("ooo_busy", 64'(busy), 64'd0);

        // full, then duplicate
        for (int i = 0; i < 4; i++) begin
            req(0, 0, 64'h500 + 64'(i) * 64'h100, 64'h0);
            tick();
        end
        req(0, 0, 64'h900, 64'h0); look();
        chk("full_ready", 64'(miss_ready), 64'd0);
`ifdef DCACHE_MSHR_MERGE_EN
        req(0, 1, 64'h500, 64'h0); look();
        chk("merge_ready", 64'(miss_ready), 64'd1);
        tick();
`endif
        for (int i = 1; i <= 4; i++) begin
            clr(); mem_resp = 4'(i); tick();
        end
        clr();
        nf = 0; n500 = 0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) begin mem_tag = 4'(i); mem_data = {$urandom, $urandom}; end
            else clr();
            tick(); look();
            if (fill_valid) begin
                nf++;
                if (fill_addr == 64'h500) n500++;
            end
        end
        chk("full_fill_count", 64'(nf), 64'd4);
        chk("dup_single_fill", 64'(n500), 64'd1);
        chk("full_busy", 64'(busy), 64'd0);

        // reset with two fills waiting for data
        tick(); req(0, 0, 64'hA00, 64'h0);
        tick(); req(0, 0, 64'hB00, 64'h0); mem_resp = 4'd6;
        tick(); clr(); mem_resp = 4'd7;
        tick(); clr(); look();
        chk("mid_busy_before", 64'(busy), 64'd1);
        rst = 1; #1;
        chk("mid_rst_busy",  64'(busy), 64'd0);
        chk("mid_rst_ready", 64'(miss_ready), 64'd0);
        tick(); tick();
        rst = 0; mem_tag = 4'd6; mem_data = 64'h6666;
        tick(); clr(); mem_tag = 4'd7; look();
        chk("mid_stale_tag", 64'(fill_valid), 64'd0);
        tick(); clr(); look();
        chk("mid_stale_tag2", 64'(fill_valid), 64'd0);
        chk("mid_busy_after", 64'(busy), 64'd0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int r;
            clr();
            miss_valid    = ($urandom_range(0, 1) == 1);
            miss_is_wb    = ($urandom_range(0, 3) == 0);
            miss_is_store = ($urandom_range(0, 1) == 1);
            miss_addr     = 64'h1000 + 64'($urandom_range(0, 5)) * 64'd8 + 64'($urandom_range(0, 7));
            miss_data     = {$urandom, $urandom};
            mem_data      = {$urandom, $urandom};
            if ($urandom_range(0, 9) < 6) mem_resp = free_tag();
            r = $urandom_range(0, 9);
            if (r < 4 && pend.size() != 0) mem_tag = pend[$urandom_range(0, pend.size() - 1)].tag;
            else if (r == 4) mem_tag = 4'($urandom_range(1, 15));
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 0;
        clr();
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
